// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART receiver with mid-bit sampling and a valid/ready output register
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CW               = $clog2(PULSE_WIDTH);
  localparam int BW               = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] PW_M1   = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_PULSE_WIDTH - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  deliver;
  logic                  rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], uart_in};
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      S_WAIT_IDLE: begin
        // Demand a full bit-time of idle line before looking for a start edge
        if (!rx_s)                 clk_cnt_d = PW_M1;
        else if (clk_cnt_q == '0)  state_d   = S_IDLE;
        else                       clk_cnt_d = clk_cnt_q - CW'(1);
      end
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          clk_cnt_d = HALF_M1;
        end
      end
      S_START: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end else if (!rx_s) begin
          state_d   = S_DATA;
          clk_cnt_d = PW_M1;
          bit_cnt_d = '0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_DATA: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end else begin
          shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
          clk_cnt_d = PW_M1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = S_IDLE;
          deliver = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_IDLE;
          clk_cnt_d   = PW_M1;
        end
      end
      default: begin
        state_d   = S_WAIT_IDLE;
        clk_cnt_d = PW_M1;
      end
    endcase

    // A pending word is only replaced if it is consumed in the same cycle
    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= S_WAIT_IDLE;
      clk_cnt_q   <= PW_M1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int PW       = CLK_FREQ / BAUD;
  localparam int LAT      = PW / 2 + 9 * PW + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int hi_cnt = 0;
  logic prev_v = 1'b0;

  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         ferr_cyc[$];
  int         ovr_cyc[$];
  int         exp_rise_cyc[$];
  logic [7:0] exp_rise_dat[$];
  int         exp_ferr_cyc[$];
  int         exp_ovr_cyc[$];
  bit         m_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !prev_v) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(data);
    end
    if (frame_err) ferr_cyc.push_back(cyc);
    if (overrun)   ovr_cyc.push_back(cyc);
    if (valid)     hi_cnt++;
    prev_v = valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: every frame resolves LAT cycles after its falling edge
  task automatic model_frame(input int fall, input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_ferr_cyc.push_back(fall + LAT);
    end else if (m_pending) begin
      exp_ovr_cyc.push_back(fall + LAT);
    end else begin
      exp_rise_cyc.push_back(fall + LAT);
      exp_rise_dat.push_back(b);
      if (!ready) m_pending = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit modeled);
    int fall;
    fall = cyc;
    uart_in = 1'b0;
    idle(PW);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      idle(PW);
    end
    uart_in = stop_ok;
    idle(PW);
    uart_in = 1'b1;
    if (modeled) model_frame(fall, b, stop_ok);
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, "_nrise"}, rise_cyc.size(), exp_rise_cyc.size());
    chk({tag, "_nferr"}, ferr_cyc.size(), exp_ferr_cyc.size());
    chk({tag, "_novr"},  ovr_cyc.size(),  exp_ovr_cyc.size());
    n = (rise_cyc.size() < exp_rise_cyc.size()) ? rise_cyc.size() : exp_rise_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rise_cyc"}, rise_cyc[i], exp_rise_cyc[i]);
      chk({tag, "_rise_dat"}, rise_dat[i], exp_rise_dat[i]);
    end
    n = (ferr_cyc.size() < exp_ferr_cyc.size()) ? ferr_cyc.size() : exp_ferr_cyc.size();
    for (int i = 0; i < n; i++) chk({tag, "_ferr_cyc"}, ferr_cyc[i], exp_ferr_cyc[i]);
    n = (ovr_cyc.size() < exp_ovr_cyc.size()) ? ovr_cyc.size() : exp_ovr_cyc.size();
    for (int i = 0; i < n; i++) chk({tag, "_ovr_cyc"}, ovr_cyc[i], exp_ovr_cyc[i]);
    rise_cyc.delete(); rise_dat.delete(); ferr_cyc.delete(); ovr_cyc.delete();
    exp_rise_cyc.delete(); exp_rise_dat.delete(); exp_ferr_cyc.delete(); exp_ovr_cyc.delete();
  endtask

  initial begin
    int h0;
    int f1;
    logic [7:0] b;
    bit ok;

    rst = 1'b1; uart_in = 1'b1; ready = 1'b1;
    idle(2);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(12);
    verify("rst");

    h0 = hi_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("a5_valid_drop", valid, 0);
    chk("a5_valid_width", hi_cnt - h0, 1);
    verify("a5");

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(3);
    if (rise_cyc.size() == 2) chk("b2b_spacing", rise_cyc[1] - rise_cyc[0], 100);
    else chk("b2b_two_words", rise_cyc.size(), 2);
    verify("b2b");

    ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(3);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_data_held", data, 8'h3C);
    ready = 1'b1;
    m_pending = 1'b0;
    idle(1);
    chk("ovr_valid_clear", valid, 0);
    idle(5);
    chk("ovr_no_redeliver", valid, 0);
    verify("ovr");

    send_frame(8'h55, 1'b0, 1'b1);
    chk("ferr_valid_low", valid, 0);
    idle(12);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(2);
    verify("ferr");

    uart_in = 1'b0;
    idle(3);
    uart_in = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2);
    verify("glitch");

    f1 = cyc;
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        idle(PW * 5 + PW / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    join
    chk("mrst_quiet", rise_cyc.size() + ferr_cyc.size() + ovr_cyc.size(), 0);
    idle(12);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(2);
    chk("mrst_elapsed", (cyc - f1) > 200, 1);
    verify("mrst");

    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, 1'b1);
      if (ok) idle($urandom_range(0, 4));
      else    idle(15 + $urandom_range(0, 5));
    end
    idle(5);
    verify("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for 8N1-style frames: oversamples `uart_in` with the system clock, validates the start bit at mid-bit, and samples each data bit and the stop bit at its centre. It deserialises LSB first and presents each completed word on a valid/ready output register. It is the receive-side counterpart of the board UART transmitter, placed between the external RX pin and fabric logic such as the command parser or a FIFO.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (no parity, one stop bit)
- `BAUD_RATE`, 115200, line baud rate
- `CLK_FREQ`, 100_000_000, `clk` frequency in Hz
- Derived (localparam): `PULSE_WIDTH = CLK_FREQ/BAUD_RATE`, `HALF_PULSE_WIDTH = PULSE_WIDTH/2`; `PULSE_WIDTH >= 4` required
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `uart_in` in 1: asynchronous serial line, idle high
- `data` out DATA_WIDTH: received word, LSB = first bit on the line
- `valid` out 1: `data` holds an unconsumed word
- `ready` in 1: consumer accepts `data` when `valid && ready`
- `frame_err` out 1: one-cycle pulse when the stop bit samples low
- `overrun` out 1: one-cycle pulse when a completed word is dropped because `valid` was still pending

## Operation
- Input synchronizer: two flops, both reset to 1. The FSM sees only the synchronized line `rx_s`.
- States:
  - WAIT_IDLE (reset state): `clk_cnt` is reloaded with `PULSE_WIDTH-1` whenever `rx_s==0` and decrements while `rx_s==1`. When it reaches 0 with `rx_s==1` -> IDLE. Guarantees at least one bit-time of idle line before start detection.
  - IDLE: `rx_s==0` -> START, with `clk_cnt <= HALF_PULSE_WIDTH-1`.
  - START: decrement `clk_cnt`; at 0, sample `rx_s`. If low -> DATA, `clk_cnt <= PULSE_WIDTH-1`, `bit_cnt <= 0`. If high (glitch) -> IDLE, nothing reported.
  - DATA: decrement `clk_cnt`; at 0, shift `rx_s` into the MSB of the shift register (right shift), reload `PULSE_WIDTH-1`. After `DATA_WIDTH` samples -> STOP.
  - STOP: decrement; at 0, sample `rx_s`. If 1 -> deliver the word, then IDLE. If 0 -> `frame_err` pulse, word discarded, then WAIT_IDLE (covers break condition).
- Delivery, evaluated in the stop-sample cycle:
  - If `valid==0`, or `valid && ready` in that same cycle: `data <= shift`, `valid <= 1`.
  - Otherwise: the old `data` and `valid` are kept, and `overrun` pulses.
- `valid` clears on `valid && ready` when no delivery happens in the same cycle. `data` is stable while `valid==1`.
- `bit_cnt` has width `$clog2(DATA_WIDTH+1)`. `clk_cnt` has width `$clog2(PULSE_WIDTH)` and never wraps; loads are always below `PULSE_WIDTH`.
- Illegal state encoding -> WAIT_IDLE.

## Timing
- Reset values (one cycle of `rst` is sufficient):
  - `valid=0`, `data=0`, `frame_err=0`, `overrun=0`
  - state WAIT_IDLE, synchronizer flops = 1
- Reset mid-frame: the frame is aborted and no output is produced. The receiver then requires `PULSE_WIDTH` consecutive high `rx_s` cycles before it accepts a start.
- Let `t_e` be the cycle in which `uart_in` falls, registered by the first synchronizer flop. Then:
  - IDLE sees `rx_s==0` at `t0 = t_e+2`.
  - Start sample at `t0+HALF_PULSE_WIDTH`.
  - Data bit i sampled at `t0+HALF_PULSE_WIDTH+(i+1)*PULSE_WIDTH`.
  - Stop sample at `t0+HALF_PULSE_WIDTH+(DATA_WIDTH+1)*PULSE_WIDTH`.
  - `valid`, `frame_err` and `overrun` assert in the following cycle.
- Back-to-back frames: the next start edge may arrive immediately after the stop-bit centre. IDLE is entered in the cycle after the stop sample.
- `ready` has no combinational path to any output.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD_RATE=100_000` (`PULSE_WIDTH=10`, `HALF_PULSE_WIDTH=5`), `ready=1` unless stated, and release `rst` with `uart_in=1` for at least 12 cycles first.
- Single frame 0xA5, driven at 10 cycles/bit -> `valid` rises exactly 98 cycles after the `uart_in` fall, `data=8'hA5`, `valid` drops the next cycle, `frame_err=0`, `overrun=0`.
- Back-to-back frames 0x00 then 0xFF, no idle gap, `ready=1` -> two `valid` pulses 100 cycles apart, with `data=8'h00` then `data=8'hFF`.
- Hold `ready=0` and send 0x3C then 0xC3 -> `data` stays `8'h3C` and `valid` stays 1. `overrun` pulses once at the second frame's stop sample. Raising `ready` afterwards clears `valid` after one accept, and 0xC3 is never delivered.
- Drive the stop bit low on frame 0x55 -> `frame_err` pulses 1 cycle and `valid` stays 0. A following frame 0x12 sent after 10 or more idle-high cycles is received correctly.
- Pull `uart_in` low for 3 cycles only -> START rejects it at the mid-bit sample; no `valid`, `frame_err` or `overrun`. A subsequent frame 0x81 is received correctly.
- Assert `rst` for 1 cycle during data bit 4 of frame 0xF0 -> no outputs for that frame; a valid 0x0F frame sent after 10 or more idle cycles yields `data=8'h0F`.
